// File: rtl/tsetlin_feedback_scheduler.sv
// rtl/tsetlin_feedback_scheduler.sv - Bank of Tsetlin automata sharing one round-robin arbitrated update datapath
module tsetlin_feedback_scheduler #(
    parameter int N_AUTOMATA = 4,
    parameter int STATE_BITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_req,
    input  logic [N_AUTOMATA-1:0] req,
    input  logic [N_AUTOMATA-1:0] beta,
    output logic [N_AUTOMATA-1:0] grant,
    output logic [N_AUTOMATA-1:0] alpha,
    output logic                  ready
);
    localparam int N  = N_AUTOMATA;
    localparam int SB = STATE_BITS;
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [SB-1:0] S_INIT = {1'b0, {(SB-1){1'b1}}};
    localparam logic [SB-1:0] S_ONE  = SB'(1);
    localparam logic [SB-1:0] S_MIN  = '0;
    localparam logic [SB-1:0] S_MAX  = '1;

    logic [0:0]    fsm;
    logic [PW-1:0] idx;
    logic [PW-1:0] ptr;
    logic [SB-1:0] bank [N];

    logic [N-1:0]  elig;
    logic [N-1:0]  nxt_grant;
    logic [PW-1:0] nxt_ptr;
    logic          found;
    int            j;

    // MSB of the state is the action; saturation only happens deep inside each half
    function automatic logic [SB-1:0] next_state(input logic [SB-1:0] s, input logic b);
        logic [SB-1:0] r;
        if (b) begin
            if (!s[SB-1]) r = (s == S_MIN) ? S_MIN : s - S_ONE;
            else          r = (s == S_MAX) ? S_MAX : s + S_ONE;
        end else begin
            if (!s[SB-1]) r = s + S_ONE;
            else          r = s - S_ONE;
        end
        return r;
    endfunction

    assign ready = (fsm == ST_RUN);

    always_comb begin
        for (int i = 0; i < N; i++) begin
            alpha[i] = ready & bank[i][SB-1];
        end
    end

    // The automaton being updated right now is masked so it cannot win twice in a row
    always_comb begin
        elig      = req & ~grant;
        nxt_grant = '0;
        nxt_ptr   = ptr;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && elig[j]) begin
                found        = 1'b1;
                nxt_grant[j] = 1'b1;
                nxt_ptr      = (j == N - 1) ? '0 : PW'(j + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm   <= ST_INIT;
            idx   <= '0;
            ptr   <= '0;
            grant <= '0;
        end else begin
            case (fsm)
                ST_INIT: begin
                    bank[idx] <= S_INIT;
                    grant     <= '0;
                    if (init_req) begin
                        idx <= '0;
                        ptr <= '0;
                    end else if (idx == PW'(N - 1)) begin
                        fsm <= ST_RUN;
                    end else begin
                        idx <= idx + PW'(1);
                    end
                end
                default: begin
                    for (int i = 0; i < N; i++) begin
                        if (grant[i]) bank[i] <= next_state(bank[i], beta[i]);
                    end
                    if (init_req) begin
                        fsm   <= ST_INIT;
                        idx   <= '0;
                        ptr   <= '0;
                        grant <= '0;
                    end else begin
                        grant <= nxt_grant;
                        ptr   <= nxt_ptr;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tsetlin_feedback_scheduler.sv
// tb/tb_tsetlin_feedback_scheduler.sv - Directed and randomized checks of the automata scheduler against a cycle model
module tb_tsetlin_feedback_scheduler;
    localparam int N = 4;
    localparam int SB = 3;
    localparam int H = 1 << (SB - 1);
    localparam int M = (1 << SB) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         init_req;
    logic [N-1:0] req;
    logic [N-1:0] beta;
    logic [N-1:0] grant;
    logic [N-1:0] alpha;
    logic         ready;

    int errors = 0;
    int checks = 0;

    int           mst [N];
    int           mrun;
    int           midx;
    int           mptr;
    logic [N-1:0] mg;

    tsetlin_feedback_scheduler #(.N_AUTOMATA(N), .STATE_BITS(SB)) dut (
        .clk(clk), .rst_n(rst_n), .init_req(init_req), .req(req), .beta(beta),
        .grant(grant), .alpha(alpha), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_next(input int s, input logic b);
        if (b) return (s < H) ? ((s > 0) ? s - 1 : 0) : ((s < M) ? s + 1 : M);
        return (s < H) ? s + 1 : s - 1;
    endfunction

    task automatic model_step();
        int pick;
        if (!rst_n) begin
            mg = '0; mrun = 0; midx = 0; mptr = 0;
        end else if (mrun == 0) begin
            mst[midx] = H - 1;
            mg = '0;
            if (init_req) begin
                midx = 0; mptr = 0;
            end else if (midx == N - 1) mrun = 1;
            else midx++;
        end else begin
            for (int i = 0; i < N; i++) if (mg[i]) mst[i] = ref_next(mst[i], beta[i]);
            if (init_req) begin
                mrun = 0; midx = 0; mptr = 0; mg = '0;
            end else begin
                pick = -1;
                for (int k = 0; k < N; k++)
                    if (pick < 0 && req[(mptr + k) % N] && !mg[(mptr + k) % N]) pick = (mptr + k) % N;
                if (pick >= 0) begin
                    mg = '0; mg[pick] = 1'b1; mptr = (pick + 1) % N;
                end else mg = '0;
            end
        end
    endtask

    task automatic check_all();
        logic [N-1:0] ea;
        for (int i = 0; i < N; i++) ea[i] = (mrun == 1) && (mst[i] >= H);
        chk("grant", grant, mg);
        chk("ready", ready, mrun == 1);
        chk("alpha", alpha, ea);
        if (mrun == 1)
            for (int i = 0; i < N; i++) chk($sformatf("state%0d", i), dut.bank[i], mst[i]);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic single_upd(input int i, input logic b);
        req[i] = 1'b1; beta[i] = b;
        tick();
        req[i] = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < N; i++) mst[i] = 0;
        mrun = 0; midx = 0; mptr = 0; mg = '0;
        rst_n = 1'b0; init_req = 1'b0; req = '0; beta = '0;
        tick();
        tick();
        chk("t1_reset_grant", grant, 0);
        chk("t1_reset_alpha", alpha, 0);

        rst_n = 1'b1;
        for (int c = 1; c <= N; c++) begin
            tick();
            chk("t1_ready_walk", ready, c == N);
            chk("t1_grant_walk", grant, 0);
        end
        chk("t1_alpha_run", alpha, 0);

        req = 4'b0100; beta = 4'b0000;
        tick();
        chk("t2_grant", grant, 4'b0100);
        req = '0;
        tick();
        chk("t2_grant_drop", grant, 0);
        chk("t2_alpha2", alpha, 4'b0100);
        chk("t2_state2", dut.bank[2], 4);

        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        for (int c = 0; c < N; c++) tick();
        req = 4'b1111; beta = 4'b1111;
        for (int c = 0; c < 2 * N; c++) begin
            logic [N-1:0] eg;
            eg = '0; eg[c % N] = 1'b1;
            tick();
            chk("t3_rr_grant", grant, eg);
        end
        req = '0;
        tick();

        for (int t = 0; t < 8 && mst[0] != 0; t++) single_upd(0, 1'b1);
        single_upd(0, 1'b1);
        single_upd(0, 1'b1);
        chk("t4_sat_low", dut.bank[0], 0);
        for (int t = 0; t < 8 && mst[1] < H; t++) single_upd(1, 1'b0);
        for (int t = 0; t < 5; t++) single_upd(1, 1'b1);
        chk("t4_sat_high", dut.bank[1], 7);
        chk("t4_alpha1", alpha[1], 1);

        for (int t = 0; t < 8 && mst[3] != 5; t++) single_upd(3, (mst[3] < H) ? 1'b0 : 1'b1);
        chk("t5_state3_pre", dut.bank[3], 5);
        req[3] = 1'b1; beta[3] = 1'b1;
        tick();
        chk("t5_grant3", grant, 4'b1000);
        req = '0; init_req = 1'b1;
        tick();
        chk("t5_ready_drop", ready, 0);
        chk("t5_no_grant", grant, 0);
        init_req = 1'b0;
        for (int c = 0; c < N; c++) tick();
        for (int i = 0; i < N; i++) chk("t5_state_init", dut.bank[i], 3);
        chk("t5_alpha", alpha, 0);
        chk("t5_ready", ready, 1);
        req = 4'b1111; beta = 4'b0000;
        tick();
        chk("t5_ptr_zero", grant, 4'b0001);
        req = '0;
        tick();

        req[1] = 1'b1; beta[1] = 1'b0;
        tick();
        chk("t6_grant1", grant, 4'b0010);
        req = '0; rst_n = 1'b0;
        tick();
        chk("t6_no_update", dut.bank[1], 3);
        chk("t6_grant_cleared", grant, 0);
        rst_n = 1'b1;
        for (int c = 0; c < N; c++) tick();
        chk("t6_state1", dut.bank[1], 3);
        chk("t6_ready", ready, 1);

        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            init_req = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < N; i++) begin
                if (req[i] && mg[i]) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    beta[i] = 1'($urandom_range(0, 1));
                end
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
